// File: rtl/wport_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package wport_pkg;

  localparam int         N_REQ    = 3;
  localparam logic [1:0] SEL_ALU  = 2'b00;  // requester 0, dest rd
  localparam logic [1:0] SEL_LOAD = 2'b01;  // requester 1, dest rt
  localparam logic [1:0] SEL_LINK = 2'b10;  // requester 2, dest $31
  localparam logic [4:0] REG_RA   = 5'd31;

  // Round-robin successor of a requester index, wrapping 2 -> 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] g);
    return (g == SEL_LINK) ? SEL_ALU : g + 2'd1;
  endfunction

endpackage

// File: rtl/rf_wport_arbiter_pick.sv
// Rotate-priority encoder: first asserted req at or after ptr (mod 3).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller gates the result with its own stall.
//
// Ports:
//   req    in  3  request vector, bit i = requester i
//   ptr    in  2  highest-priority requester index (0..2)
//   onehot out 3  one-hot winner, 0 when nothing requests
//   idx    out 2  winner index (SEL_ALU when nothing requests)
//   valid  out 1  at least one request asserted
import wport_pkg::*;

module rr_pick_3 (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [1:0]       idx,
  output logic             valid
);

  logic [1:0] cand [N_REQ];

  always_comb begin
    // Candidates in priority order: ptr, ptr+1, ptr+2 (mod 3).
    cand[0] = ptr;
    cand[1] = next_ptr(ptr);
    cand[2] = next_ptr(next_ptr(ptr));
    onehot  = '0;
    idx     = SEL_ALU;
    valid   = 1'b0;
    // Walk from lowest priority up so the highest-priority hit is the last write.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        onehot = 3'b001 << cand[k];
        idx    = cand[k];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Round-robin share of the register-file write port among ALU, load and link writeback.
// Latency: ack is combinational in the grant cycle; wr_en/addr/data/sel appear one cycle later.
// Backpressure: stall=1 withholds any grant; requesters hold req/dest/data until acked.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   stall                  hazard-unit stall, no grant while high
//   req[2:0]               write requests (0=ALU, 1=load, 2=link)
//   dest0..2 / data0..2    destination register and write data per requester
//   ack[2:0]               one-hot grant pulse, same cycle as the grant
//   sel[1:0]               registered select for the external destination mux
//   wr_en/wr_addr/wr_data  registered register-file write port
//
// Optional build macro RF_WPORT_ZERO_SQUASH_EN: a granted write to $0 is acked and
// advances fairness but is issued with wr_en=0. Without it the write goes out and
// the register file discards it.
import wport_pkg::*;

module rf_wport_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] dest0,
  input  logic [ADDR_W-1:0] dest1,
  input  logic [ADDR_W-1:0] dest2,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [2:0]        ack,
  output logic [1:0]        sel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic [1:0]        ptr;
  logic [2:0]        pick_onehot;
  logic [1:0]        pick_idx;
  logic              pick_valid;
  logic              grant;
  logic [ADDR_W-1:0] dest_g;
  logic [DATA_W-1:0] data_g;

  rr_pick_3 u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Reset suppresses the grant so a pending request survives to arbitrate from ptr=0.
  assign grant = pick_valid && !stall && !rst;
  assign ack   = grant ? pick_onehot : 3'b000;

  always_comb begin
    dest_g = dest0;
    data_g = data0;
    case (pick_idx)
      SEL_LOAD: begin
        dest_g = dest1;
        data_g = data1;
      end
      SEL_LINK: begin
        dest_g = dest2;
        data_g = data2;
      end
      default: begin
        dest_g = dest0;
        data_g = data0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= SEL_ALU;
      sel     <= SEL_ALU;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (grant) begin
      // Fairness advances only on a grant, never on a stalled cycle.
      ptr     <= next_ptr(pick_idx);
      sel     <= pick_idx;
      wr_addr <= dest_g;
      wr_data <= data_g;
`ifdef RF_WPORT_ZERO_SQUASH_EN
      wr_en   <= (dest_g != '0);
`else
      wr_en   <= 1'b1;
`endif
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule
